// File: rtl/rotation_sequencer.sv
// Timed rotation-select generator for the three-position HEX character rotator.
// A prescaler paces automatic advances; while paused, a Step rising edge advances once.
module rotation_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int CW       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       dir,
  input  logic       step,
  output logic [1:0] sel,
  output logic       tick
);

  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          step_q;
  logic          step_rise;
  logic          wrap;
  logic          advance;

  // Code 11 is unreachable; it falls back to 00 so a corrupted select self-heals.
  function automatic logic [1:0] next_sel(input logic [1:0] cur, input logic backward);
    logic [1:0] nxt;
    nxt = 2'b00;
    unique case (cur)
      2'b00:   nxt = backward ? 2'b10 : 2'b01;
      2'b01:   nxt = backward ? 2'b00 : 2'b10;
      2'b10:   nxt = backward ? 2'b01 : 2'b00;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  assign step_rise = step & ~step_q;
  assign wrap      = (cnt == CNT_LAST);
  assign advance   = enable ? wrap : step_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      sel    <= 2'b00;
      tick   <= 1'b0;
      step_q <= 1'b0;
    end else begin
      step_q <= step;
      tick   <= advance;
      if (advance) begin
        sel <= next_sel(sel, dir);
      end
      // Paused: cnt freezes, except a manual step restarts a full period.
      if (enable) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end else if (step_rise) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: doc/rotation_sequencer.md
# rotation_sequencer

Generates the 2-bit rotation select that drives the three-position character rotator feeding HEX2..HEX0. It replaces the manual SW[9:8] select with a timed, free-running advance. A programmable prescaler divides the board clock into step ticks, and each tick advances the select through the three legal codes in the chosen direction. A paused mode allows single-stepping from a pushbutton-style input.

## Interface
- TICK_DIV, default 50000000: clock cycles per automatic advance (1 s at 50 MHz); legal range 1 .. 2^26.
- CW, default 26: prescaler counter width; must satisfy 2^CW >= TICK_DIV.
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset; dominates every other input.
- Enable  in  1  1 = run (automatic advance), 0 = paused.
- Dir  in  1  0 = forward (00→01→10→00), 1 = backward (00→10→01→00).
- Step  in  1  level input, already debounced; its rising edge requests one advance while paused.
- Sel  out  2  rotation select to the rotator; only 00, 01, 10 are ever driven.
- Tick  out  1  one-cycle pulse, registered, high in the cycle in which Sel holds a newly advanced value.

## Operation
- State elements:
  - prescaler `cnt` [CW-1:0]
  - `Sel` register
  - `Tick` register
  - `step_q` (previous Step sample)
- Reset: cnt=0, Sel=00, Tick=0, step_q=0. This applies whether or not an advance was pending; no partial advance survives reset.
- Edge detect: `step_rise` = Step & ~step_q. step_q <= Step every non-reset cycle, regardless of Enable.
- Run mode (Enable=1):
  - If cnt == TICK_DIV-1, then cnt <= 0 and an advance occurs. Otherwise cnt <= cnt+1.
  - step_rise is ignored.
- Paused mode (Enable=0):
  - cnt holds its value.
  - step_rise causes one advance and clears cnt to 0, so the next run period is a full TICK_DIV.
- Advance: Sel <= next(Sel, Dir) and Tick <= 1. In every cycle without an advance, Tick <= 0.
- next() for Dir=0: 00→01, 01→10, 10→00.
- next() for Dir=1: 00→10, 10→01, 01→00.
- Illegal code 11 (unreachable) maps to 00 under either Dir.
- Dir is sampled only at the advance edge. Changing Dir between advances has no other effect.
- Enable toggling: going 1→0 freezes cnt mid-count. Going 0→1 resumes from the frozen cnt.
- Enable toggling and Step rising in the same cycle: Enable as sampled at that edge decides. If Enable=1, the step is dropped.
- Holding Step high produces exactly one advance. A new advance requires Step to return low for at least one cycle.

## Timing
- Run mode:
  - Advances occur every TICK_DIV cycles.
  - The first advance after reset release occurs at the TICK_DIV-th rising edge with Enable=1.
- Tick coincides exactly with the first cycle of each new Sel value. Latency from the advance decision to Sel/Tick is zero additional cycles, since both are registered at the same edge.
- Step latency: if Step is first sampled high at edge k (with step_q=0), Sel changes and Tick rises at edge k.
- TICK_DIV=1:
  - Sel advances every cycle while enabled.
  - Tick stays high continuously while enabled.
- Sel is glitch-free because it is a direct register output. The downstream rotator is purely combinational, so HEX updates in the same cycle.

## Test plan
- Reset and free run (TICK_DIV=4, Enable=1, Dir=0) → Sel=00 for 4 cycles after reset, then 01, then 10, then 00, each held 4 cycles. Tick is high exactly on cycles 4, 8, 12.
- Backward run (Dir=1) from Sel=00 → sequence 10, 01, 00. Flip Dir to 0 mid-period while Sel=10 → the next advance gives 00.
- Pause and step:
  - Enable=0 with cnt=2 → Sel holds and cnt holds at 2.
  - Step 0→1 → Sel advances once, Tick=1 for one cycle, cnt=0.
  - Step held high 10 cycles → no further advance.
  - Step low, then high again → one more advance.
- Step while running: Enable=1, Step pulses → no extra advances; the Tick spacing stays exactly 4 cycles.
- Reset mid-count: assert Reset with cnt=3 and Sel=10, Enable=1 → on the next edge Sel=00, Tick=0, cnt=0. No advance occurs on the reset edge, even though cnt was TICK_DIV-1.
- TICK_DIV=1 with Enable=1 → Sel cycles 01, 10, 00, … every cycle and Tick stays high. Sel never equals 11 across all scenarios (continuous assertion).
